// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory arbiter.
package mem_arb_pkg;

    // Which port the response arriving next cycle belongs to
    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_IF   = 2'd1,
        S_DRD  = 2'd2,
        S_DWR  = 2'd3
    } owner_e;

    localparam int ADDR_W_DEF     = 29;
    localparam int DATA_W_DEF     = 64;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority select: data normally wins, fetch is forced through
// after STARVE_MAX consecutive denied cycles.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        if_gnt = if_req && (!d_req || starved);
        d_gnt  = d_req && !if_gnt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 1-cycle-latency memory port between instruction fetch and
// load/store traffic, routing each read response back to its issuer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W/2-1:0]   if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    owner_e                state;
    logic                  if_sel_q;
    logic [DATA_W/2-1:0]   if_rdata_q;
    logic [DATA_W-1:0]     d_rdata_q;
    logic [DATA_W/2-1:0]   if_half;
    logic                  unused_bits;

    // Sub-doubleword offsets are don't-care (fetch uses bit 2 for the half select)
    assign unused_bits = ^{if_addr[1:0], d_addr[2:0]};

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk    (clk),
        .nrst   (nrst),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (if_gnt) begin
            mem_addr = if_addr[ADDR_W+2:3];
        end else if (d_gnt) begin
            mem_addr = d_addr[ADDR_W+2:3];
            if (d_we) begin
                mem_wr_en = 1'b1;
                mem_wdata = d_wdata;
                mem_wmask = d_wmask;
            end
        end
    end

    // Owner FSM; rvalids are registered alongside the state they decode
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_NONE;
            if_sel_q  <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt && !d_we;
            if (if_gnt) begin
                state    <= S_IF;
                if_sel_q <= if_addr[2];
            end else if (d_gnt) begin
                state <= d_we ? S_DWR : S_DRD;
            end else begin
                state <= S_NONE;
            end
        end
    end

    assign if_half  = if_sel_q ? mem_rdata[DATA_W-1:DATA_W/2] : mem_rdata[DATA_W/2-1:0];
    // Response data passes straight through in its cycle and is held afterwards
    assign if_rdata = (state == S_IF)  ? if_half   : if_rdata_q;
    assign d_rdata  = (state == S_DRD) ? mem_rdata : d_rdata_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == S_IF)  if_rdata_q <= if_half;
            if (state == S_DRD) d_rdata_q  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic [28:0] mem_addr;
    logic        mem_wr_en;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem    [0:63];
    logic [63:0] shadow [0:63];
    logic [31:0] if_q[$];
    logic [63:0] d_q[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // Behavioural memory with 1-cycle read latency and byte-masked writes
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[5:0]];
        if (mem_wr_en)
            for (int b = 0; b < 8; b++)
                if (mem_wmask[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: check grants, mem drive and responses, then record the expected response
    task automatic tick(input logic exp_ig, input logic exp_dg, input string tag);
        logic [63:0] w;
        @(negedge clk);
        chk({tag, ".if_gnt"}, if_gnt, exp_ig);
        chk({tag, ".d_gnt"}, d_gnt, exp_dg);
        if (if_q.size() > 0) begin
            chk({tag, ".if_rvalid"}, if_rvalid, 1'b1);
            chk({tag, ".if_rdata"}, if_rdata, if_q.pop_front());
        end else begin
            chk({tag, ".if_rvalid0"}, if_rvalid, 1'b0);
        end
        if (d_q.size() > 0) begin
            chk({tag, ".d_rvalid"}, d_rvalid, 1'b1);
            chk({tag, ".d_rdata"}, d_rdata, d_q.pop_front());
        end else begin
            chk({tag, ".d_rvalid0"}, d_rvalid, 1'b0);
        end
        if (exp_ig) begin
            chk({tag, ".mem_addr"}, mem_addr, if_addr[31:3]);
            chk({tag, ".mem_wr_en"}, mem_wr_en, 1'b0);
            chk({tag, ".mem_wmask"}, mem_wmask, 8'h00);
            w = shadow[if_addr[8:3]];
            if_q.push_back(if_addr[2] ? w[63:32] : w[31:0]);
        end else if (exp_dg) begin
            chk({tag, ".mem_addr"}, mem_addr, d_addr[31:3]);
            chk({tag, ".mem_wr_en"}, mem_wr_en, d_we);
            chk({tag, ".mem_wmask"}, mem_wmask, d_we ? d_wmask : 8'h00);
            if (d_we) begin
                chk({tag, ".mem_wdata"}, mem_wdata, d_wdata);
                for (int b = 0; b < 8; b++)
                    if (d_wmask[b]) shadow[d_addr[8:3]][b*8 +: 8] = d_wdata[b*8 +: 8];
            end else begin
                d_q.push_back(shadow[d_addr[8:3]]);
            end
        end else begin
            chk({tag, ".idle_addr"}, mem_addr, 29'd0);
            chk({tag, ".idle_wr_en"}, mem_wr_en, 1'b0);
            chk({tag, ".idle_wmask"}, mem_wmask, 8'h00);
            chk({tag, ".idle_wdata"}, mem_wdata, 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = {32'hC0DE_0000 + i, 32'h0000_1000 + i * 3};
            shadow[i] = {32'hC0DE_0000 + i, 32'h0000_1000 + i * 3};
        end
        mem[1]    = 64'hAAAA_BBBB_1111_2222;
        shadow[1] = 64'hAAAA_BBBB_1111_2222;
        mem[4]    = '1;
        shadow[4] = '1;

        nrst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.if_rvalid", if_rvalid, 1'b0);
        chk("rst.d_rvalid", d_rvalid, 1'b0);
        chk("rst.if_rdata", if_rdata, 32'd0);
        chk("rst.d_rdata", d_rdata, 64'd0);
        chk("rst.mem_addr", mem_addr, 29'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // idle
        repeat (3) tick(1'b0, 1'b0, "idle");

        // fetch only, upper half selected
        if_req = 1'b1; if_addr = 32'h0C;
        tick(1'b1, 1'b0, "fetch");
        if_req = 1'b0;
        tick(1'b0, 1'b0, "fetch_rsp");
        chk("fetch.hold", if_rdata, 32'hAAAA_BBBB);

        // store then load of the same doubleword
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
        d_wdata = 64'h1122_3344_5566_7788; d_wmask = 8'h0F;
        tick(1'b0, 1'b1, "store");
        d_we = 1'b0;
        tick(1'b0, 1'b1, "load");
        d_req = 1'b0;
        tick(1'b0, 1'b0, "load_rsp");
        chk("load.hold", d_rdata, 64'hFFFF_FFFF_5566_7788);

        // store produces no response and leaves d_rdata alone
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h28;
        d_wdata = 64'hDEAD_BEEF_0BAD_F00D; d_wmask = 8'hFF;
        tick(1'b0, 1'b1, "wr");
        d_req = 1'b0;
        tick(1'b0, 1'b0, "wr_rsp");
        chk("wr.d_rdata_hold", d_rdata, 64'hFFFF_FFFF_5566_7788);

        // zero-mask store consumes a cycle but changes nothing
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00;
        d_wdata = 64'h5555_5555_5555_5555; d_wmask = 8'h00;
        tick(1'b0, 1'b1, "wm0");
        d_we = 1'b0;
        tick(1'b0, 1'b1, "wm0_ld");
        d_req = 1'b0;
        tick(1'b0, 1'b0, "wm0_rsp");

        // contention: 4 data grants then a forced fetch, twice
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h28;
        for (int r = 0; r < 2; r++) begin
            repeat (4) tick(1'b0, 1'b1, "cont_d");
            tick(1'b1, 1'b0, "cont_if");
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(1'b0, 1'b0, "cont_drain");

        // back-to-back fetches with nonzero low address bits
        if_req = 1'b1; if_addr = 32'h0F;
        tick(1'b1, 1'b0, "b2b0");
        if_addr = 32'h13;
        tick(1'b1, 1'b0, "b2b1");
        if_req = 1'b0;
        tick(1'b0, 1'b0, "b2b_rsp");

        // reset in the cycle after a fetch grant drops the response
        if_req = 1'b1; if_addr = 32'h0C;
        tick(1'b1, 1'b0, "rfetch");
        if_req = 1'b0;
        nrst = 1'b0;
        #1;
        chk("rmid.if_rvalid", if_rvalid, 1'b0);
        if_q.delete();
        d_q.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        chk("rpost.if_rdata", if_rdata, 32'd0);
        chk("rpost.d_rdata", d_rdata, 64'd0);
        repeat (2) tick(1'b0, 1'b0, "rpost");
        chk("rpost.if_rdata2", if_rdata, 32'd0);
        chk("rpost.d_rdata2", d_rdata, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
